iobuf_bank_reg: RTL and testbench
=================================

# iobuf_bank_reg

Registered, parametrised bidirectional I/O bank: WIDTH pad bits sharing one tri-state control, with a registered output path, a synchronised input path, a programmable bus-turnaround delay before driving, and an asynchronous global tri-state override. It sits between core logic and the external pads, replacing per-bit combinational tri-state buffers on shared buses where drive contention and metastable capture must be prevented.

## Interface

- WIDTH, 16, number of pad bits (1..64)
- TURNAROUND, 1, high-Z dead cycles inserted before driving after T falls (0..15)
- SYNC_STAGES, 2, input synchroniser depth (1..4)

- CLK  input  1  clock, all state on rising edge
- RST_N  input  1  reset, asynchronous, active-low
- GTS  input  1  global tri-state; 1 forces IO high-Z immediately (combinational) and aborts driving
- T  input  1  direction request: 0 = drive IO, 1 = release (high-Z)
- I  input  WIDTH  data to drive onto IO
- IO  inout  WIDTH  pad bus
- O  output  WIDTH  synchronised pad value
- BUSY  output  1  1 while in turnaround
- DRV  output  1  1 while IO is actually driven

## Operation

- Output data register out_q <= I on every clock edge, independent of state; IO = out_q when drive enable active, else all bits high-Z.
- Drive enable = (state == DRIVE) && !GTS; DRV equals drive enable.
- FSM states IDLE, TURN, DRIVE; turnaround counter cnt, 4 bits.
- IDLE: T=0 && GTS=0 -> TURN with cnt = TURNAROUND-1 (TURNAROUND=0: straight to DRIVE). Otherwise stay.
- TURN: T=1 or GTS=1 -> IDLE. Else cnt==0 -> DRIVE, else cnt decrements.
- DRIVE: T=1 or GTS=1 -> IDLE. Else stay.
- GTS has priority over T in every state.
- BUSY = (state == TURN), registered state decode, no combinational path from T.
- Input path: IO sampled into SYNC_STAGES-deep flop chain per bit; O = last stage. Capture is unconditional, so while driving O returns the driven value (loopback).
- High-Z or X bits on IO are captured as-is; no bus-keeper behaviour in this block.

## Timing

- Reset (RST_N=0, async): state IDLE, cnt 0, out_q 0, all synchroniser stages 0; O=0, BUSY=0, DRV=0, IO high-Z. Release takes effect at first rising edge with RST_N=1.
- Reset asserted mid-DRIVE or mid-TURN: IO high-Z immediately, no clock needed.
- Drive latency: T sampled 0 at edge k (from IDLE) -> BUSY=1 from edge k to edge k+TURNAROUND; DRV=1 and IO driven after edge k+TURNAROUND. TURNAROUND=0: driven after edge k, BUSY never asserts.
- Data latency: I sampled at edge m appears on IO after edge m (one register), while driving.
- Release latency: T sampled 1 at edge k in DRIVE -> IO high-Z after edge k.
- GTS: IO high-Z within the same cycle GTS rises (combinational); at next edge state -> IDLE, so when GTS falls a full turnaround is repeated before driving.
- T returns 0 during TURN is not required; any T=1 sample in TURN restarts from IDLE (no partial count retained).
- Input latency: IO value stable before edge k is on O after edge k+SYNC_STAGES-1.

## Test plan

- Reset: RST_N=0 with T=0, I=16'hFFFF for 3 cycles -> IO=16'hzzzz, O=0, BUSY=0, DRV=0; assert RST_N low again mid-DRIVE -> IO high-Z immediately.
- Turnaround, TURNAROUND=2: I=16'hA5C3, T falls before edge k -> BUSY=1 after edges k, k+1; DRV=1 and IO=16'hA5C3 after edge k+2; no cycle with BUSY and DRV both 1.
- Release and TURNAROUND=0: in DRIVE, T=1 sampled at edge k -> IO=16'hzzzz after edge k; T=0 at edge k+3 -> IO driven after edge k+3, BUSY stays 0.
- GTS override: in DRIVE with IO=16'h1234, raise GTS mid-cycle -> IO high-Z before next edge, DRV=0; drop GTS with T=0 -> TURNAROUND busy cycles repeated before IO=16'h1234 again.
- Abort in TURN, TURNAROUND=3: T=0 at edge k, T=1 at edge k+1 -> IDLE, IO never driven; T=0 at edge k+2 -> full 3-cycle turnaround again.
- Input sync, SYNC_STAGES=2, T=1: external drive IO=16'h00FF before edge k, 16'hFF00 before edge k+1 -> O=16'h00FF after edge k+1, 16'hFF00 after edge k+2; while driving 16'hBEEF, O=16'hBEEF two edges after IO changes.

Source files
------------

// File: rtl/iobuf_bank_reg_if.sv
// Core-side signals of the registered I/O bank: drive request, data, sync'd pad value, status.
// Master is the core logic, slave is the bank; the pad bus itself stays a plain inout net.
interface iobuf_bank_reg_if #(
   parameter int WIDTH = 16
);
   logic             GTS;
   logic             T;
   logic [WIDTH-1:0] I;
   logic [WIDTH-1:0] O;
   logic             BUSY;
   logic             DRV;

   modport master (output GTS, output T, output I, input O, input BUSY, input DRV);
   modport slave  (input GTS, input T, input I, output O, output BUSY, output DRV);
endinterface

// File: rtl/iobuf_bank_reg.sv
// Registered bidirectional pad bank with bus-turnaround dead time and global tri-state.
// Latency: I->IO 1 edge, IO->O SYNC_STAGES edges, T-fall->drive TURNAROUND+1 edges; GTS release is combinational.
// No backpressure: BUSY/DRV report direction state, the core simply waits for DRV.
module iobuf_bank_reg #(
   parameter int WIDTH       = 16,
   parameter int TURNAROUND  = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   iobuf_bank_reg_if.slave  bus,
   inout  wire  [WIDTH-1:0] IO
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TURN  = 2'd1,
      DRIVE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = (TURNAROUND == 0) ? 4'd0 : 4'(TURNAROUND - 1);

   state_t           state_q;
   state_t           state_d;
   logic [3:0]       cnt_q;
   logic [3:0]       cnt_d;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic             drv_en;
   logic             busy;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // GTS and T both force IDLE; leaving TURN discards the partial count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (!bus.GTS && !bus.T) begin
               if (TURNAROUND == 0) begin
                  state_d = DRIVE;
               end else begin
                  state_d = TURN;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         TURN: begin
            if (bus.GTS || bus.T) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               state_d = DRIVE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DRIVE: begin
            if (bus.GTS || bus.T) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // GTS gates the enable combinationally so the pads release before the next edge.
   always_comb begin
      busy   = (state_q == TURN);
      drv_en = (state_q == DRIVE) && !bus.GTS;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_q <= '0;
      end else begin
         out_q <= bus.I;
      end
   end

   // Capture is unconditional so a driven bus loops back onto O.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= IO;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign IO       = drv_en ? out_q : {WIDTH{1'bz}};
   assign bus.O    = sync_q[SYNC_STAGES-1];
   assign bus.BUSY = busy;
   assign bus.DRV  = drv_en;

endmodule

// File: tb/tb_iobuf_bank_reg.sv
// Directed bench for iobuf_bank_reg: three banks (TURNAROUND 2, 0, 3) share one stimulus stream.
// Released pads are checked by driving a distinct pattern externally and reading it back unchanged.
module tb_iobuf_bank_reg;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        t = 1'b0;
   logic        gts = 1'b0;
   logic [15:0] din = 16'hFFFF;
   logic        ext_en = 1'b1;
   logic [15:0] ext_val = 16'h5A5A;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   iobuf_bank_reg_if #(.WIDTH(16)) b2 ();
   iobuf_bank_reg_if #(.WIDTH(16)) b0 ();
   iobuf_bank_reg_if #(.WIDTH(16)) b3 ();

   wire [15:0] io2;
   wire [15:0] io0;
   wire [15:0] io3;

   assign io2 = ext_en ? ext_val : 16'hzzzz;
   assign io0 = ext_en ? ext_val : 16'hzzzz;
   assign io3 = ext_en ? ext_val : 16'hzzzz;

   assign b2.T = t;  assign b2.GTS = gts;  assign b2.I = din;
   assign b0.T = t;  assign b0.GTS = gts;  assign b0.I = din;
   assign b3.T = t;  assign b3.GTS = gts;  assign b3.I = din;

   iobuf_bank_reg #(.WIDTH(16), .TURNAROUND(2), .SYNC_STAGES(2)) u_dut2 (
      .CLK(CLK), .RST_N(RST_N), .bus(b2.slave), .IO(io2)
   );
   iobuf_bank_reg #(.WIDTH(16), .TURNAROUND(0), .SYNC_STAGES(2)) u_dut0 (
      .CLK(CLK), .RST_N(RST_N), .bus(b0.slave), .IO(io0)
   );
   iobuf_bank_reg #(.WIDTH(16), .TURNAROUND(3), .SYNC_STAGES(2)) u_dut3 (
      .CLK(CLK), .RST_N(RST_N), .bus(b3.slave), .IO(io3)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; bank 2 must never be busy and driving at once,
   // and the zero-turnaround bank must never report busy.
   task automatic step();
      @(posedge CLK);
      #1;
      check("excl2", {15'd0, b2.BUSY & b2.DRV}, 16'h0000);
      check("busy0_never", {15'd0, b0.BUSY}, 16'h0000);
   endtask

   initial begin
      // Reset with T=0 and I all ones: everything quiet, pads released.
      repeat (3) step();
      check("rst_O", b2.O, 16'h0000);
      check("rst_BUSY", {15'd0, b2.BUSY}, 16'h0000);
      check("rst_DRV", {15'd0, b2.DRV}, 16'h0000);
      check("rst_IO_free", io2, 16'h5A5A);

      t = 1'b1; ext_en = 1'b0; din = 16'hA5C3;
      RST_N = 1'b1;
      repeat (2) step();

      // Turnaround of 2 on bank 2.
      t = 1'b0;
      step();
      check("ta2_k_BUSY", {15'd0, b2.BUSY}, 16'h0001);
      check("ta2_k_DRV", {15'd0, b2.DRV}, 16'h0000);
      step();
      check("ta2_k1_BUSY", {15'd0, b2.BUSY}, 16'h0001);
      check("ta2_k1_DRV", {15'd0, b2.DRV}, 16'h0000);
      step();
      check("ta2_k2_BUSY", {15'd0, b2.BUSY}, 16'h0000);
      check("ta2_k2_DRV", {15'd0, b2.DRV}, 16'h0001);
      check("ta2_k2_IO", io2, 16'hA5C3);

      // One-register data path, then loopback onto O two edges after IO changes.
      din = 16'h1234;
      step();
      check("data_lat_IO", io2, 16'h1234);
      repeat (2) step();
      din = 16'hBEEF;
      step();
      check("loop_IO", io2, 16'hBEEF);
      check("loop_O_m", b2.O, 16'h1234);
      step();
      check("loop_O_m1", b2.O, 16'h1234);
      step();
      check("loop_O_m2", b2.O, 16'hBEEF);

      // Global tri-state mid-cycle while driving 1234.
      din = 16'h1234;
      step();
      check("gts_pre_IO", io2, 16'h1234);
      gts = 1'b1; ext_en = 1'b1;
      #2;
      check("gts_DRV", {15'd0, b2.DRV}, 16'h0000);
      check("gts_IO_free", io2, 16'h5A5A);
      step();
      gts = 1'b0; ext_en = 1'b0;
      step();
      check("gts_rep_k_BUSY", {15'd0, b2.BUSY}, 16'h0001);
      check("gts_rep_k_DRV", {15'd0, b2.DRV}, 16'h0000);
      step();
      check("gts_rep_k1_BUSY", {15'd0, b2.BUSY}, 16'h0001);
      step();
      check("gts_rep_k2_DRV", {15'd0, b2.DRV}, 16'h0001);
      check("gts_rep_k2_IO", io2, 16'h1234);

      // Async reset in the middle of DRIVE releases the pads with no clock.
      #2;
      RST_N = 1'b0; ext_en = 1'b1;
      #1;
      check("rst_mid_DRV", {15'd0, b2.DRV}, 16'h0000);
      check("rst_mid_IO_free", io2, 16'h5A5A);
      check("rst_mid_O", b2.O, 16'h0000);
      step();
      t = 1'b1; ext_en = 1'b0; RST_N = 1'b1;
      repeat (2) step();

      // Zero turnaround on bank 0: release and immediate re-drive.
      t = 1'b0;
      step();
      check("ta0_DRV", {15'd0, b0.DRV}, 16'h0001);
      check("ta0_IO", io0, 16'h1234);
      t = 1'b1;
      step();
      check("ta0_rel_DRV", {15'd0, b0.DRV}, 16'h0000);
      ext_en = 1'b1;
      #1;
      check("ta0_rel_IO_free", io0, 16'h5A5A);
      ext_en = 1'b0;
      step();
      step();
      t = 1'b0;
      step();
      check("ta0_redrive_DRV", {15'd0, b0.DRV}, 16'h0001);
      check("ta0_redrive_IO", io0, 16'h1234);

      // Abort inside TURN on bank 3, then a full three-cycle turnaround.
      t = 1'b1;
      repeat (2) step();
      t = 1'b0;
      step();
      check("ta3_k_BUSY", {15'd0, b3.BUSY}, 16'h0001);
      check("ta3_k_DRV", {15'd0, b3.DRV}, 16'h0000);
      t = 1'b1;
      step();
      check("ta3_abort_BUSY", {15'd0, b3.BUSY}, 16'h0000);
      check("ta3_abort_DRV", {15'd0, b3.DRV}, 16'h0000);
      t = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check("ta3_again_BUSY", {15'd0, b3.BUSY}, 16'h0001);
         check("ta3_again_DRV", {15'd0, b3.DRV}, 16'h0000);
      end
      step();
      check("ta3_done_BUSY", {15'd0, b3.BUSY}, 16'h0000);
      check("ta3_done_DRV", {15'd0, b3.DRV}, 16'h0001);
      check("ta3_done_IO", io3, 16'h1234);

      // External data through the synchroniser with all banks released.
      t = 1'b1;
      step();
      ext_en = 1'b1; ext_val = 16'h00FF;
      step();
      ext_val = 16'hFF00;
      step();
      check("sync_k1_O", b2.O, 16'h00FF);
      step();
      check("sync_k2_O", b2.O, 16'hFF00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
